// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the CPU input port: register addresses,
// status bit positions and the debounce state encoding.
package cpu_io_pkg;

    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_DATA   = 1'b1;

    localparam int STATUS_VALID_BIT = 0;
    localparam int STATUS_OVR_BIT   = 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        REL
    } deb_state_t;

endpackage

// File: rtl/debounce_fsm.sv
// Debounces a synchronised button level and emits a single-cycle press pulse
// for every accepted low->high transition.
module debounce_fsm
    import cpu_io_pkg::*;
#(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clock,
    input  logic n_reset,
    input  logic in_s,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    deb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_q;

    // Saturating increment: the counter can never wrap back into a short count.
    assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_s) begin
                        state_q <= PRESS;
                        cnt_q   <= '0;
                    end
                end
                PRESS: begin
                    if (!in_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_q <= HELD;
                            press_q <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!in_s) begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end
                end
                REL: begin
                    if (in_s) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press = press_q;

endmodule

// File: rtl/sw_input_port.sv
// Memory-mapped switch/button input port: synchronises the board inputs,
// latches the switches on each debounced ENTER press and serves CPU reads.
module sw_input_port
    import cpu_io_pkg::*;
#(
    parameter int WORD_W     = 8,
    parameter int DEB_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [WORD_W-1:0] sw,
    input  logic              btn,
    input  logic              rd,
    input  logic              addr,
    output logic [WORD_W-1:0] rdata,
    output logic              valid,
    output logic              overrun
);

    logic [1:0]        rst_sync_q;
    logic              rst_n_s;

    logic [WORD_W-1:0] sw_meta_q;
    logic [WORD_W-1:0] sw_s_q;
    logic              btn_meta_q;
    logic              btn_s_q;

    logic              press;
    logic              read_data;

    logic [WORD_W-1:0] status_word;
    logic [WORD_W-1:0] data_q,    data_d;
    logic [WORD_W-1:0] rdata_q,   rdata_d;
    logic              valid_q,   valid_d;
    logic              overrun_q, overrun_d;

    // Reset asserts immediately but is released in step with the clock.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
        end else begin
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
        end
    end

    debounce_fsm #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clock   (clock),
        .n_reset (rst_n_s),
        .in_s    (btn_s_q),
        .press   (press)
    );

    assign read_data = rd && (addr == ADDR_DATA);

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_VALID_BIT] = valid_q;
        status_word[STATUS_OVR_BIT]   = overrun_q;
    end

    // A DATA read racing a capture returns the old word and consumes only it,
    // so the fresh capture stays pending without counting as an overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        rdata_d   = rdata_q;

        if (rd) begin
            rdata_d = (addr == ADDR_DATA) ? data_q : status_word;
        end

        if (press) begin
            data_d    = sw_s_q;
            valid_d   = 1'b1;
            overrun_d = read_data ? 1'b0 : (overrun_q | valid_q);
        end else if (read_data) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            data_q    <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rdata   = rdata_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule
